kmeans_centroid_update_k3_d2: RTL and testbench

//  Consumer side of kmeans_pipeline_k3_d2, closing the k-means loop.

---
 rtl/kmeans_pkg.sv | 27 ++
 rtl/kmeans_seq_divider.sv | 78 +++++++
 rtl/kmeans_centroid_update_k3_d2.sv | 186 ++++++++++++++++++
 tb/tb_kmeans_centroid_update_k3_d2.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// kmeans_pkg
//   Shared definitions for the k-means blocks (pipeline and centroid update).
//   Holds the centroid/dimension counts, the slot numbering used to walk every
//   centroid coordinate, the centroid-update FSM encoding and width helpers.
package kmeans_pkg;

   localparam int NUM_CENTROIDS = 3;
   localparam int NUM_DIMS      = 2;
   localparam int NUM_SLOTS     = NUM_CENTROIDS * NUM_DIMS;
   localparam int SLOT_W        = 3;

   localparam int DEF_INPUT_DATA_WIDTH  = 16;
   localparam int DEF_CENTROID_ID_WIDTH = 2;
   localparam int DEF_COUNT_WIDTH       = 16;

   // An accumulator never overflows if it can hold max_count * max_value.
   function automatic int sum_width_of(input int data_width, input int count_width);
      return data_width + count_width;
   endfunction

   typedef enum logic [1:0] {
      ST_ACC  = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } kmeans_state_e;

endpackage

// File: rtl/kmeans_seq_divider.sv
// kmeans_seq_divider
//   Unsigned restoring divider, one quotient bit per cycle.
//   start (while idle) loads dividend/divisor; DIVIDEND_WIDTH iterations follow.
//   done is high during the final iteration cycle, and quotient_next holds the
//   quotient that cycle, so the caller can capture it on the same edge the
//   division finishes.
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : begin a division (ignored while busy)
//   dividend        : DIVIDEND_WIDTH-bit numerator
//   divisor         : DIVISOR_WIDTH-bit denominator (0 yields all-ones, caller ignores)
//   busy            : iterations in progress
//   done            : final iteration this cycle
//   quotient_next   : low QUOTIENT_WIDTH bits of the quotient being produced
module kmeans_seq_divider #(
   parameter int DIVIDEND_WIDTH = 32,
   parameter int DIVISOR_WIDTH  = 16,
   parameter int QUOTIENT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      busy,
   output logic                      done,
   output logic [QUOTIENT_WIDTH-1:0] quotient_next
);

   localparam int CNT_W = $clog2(DIVIDEND_WIDTH);
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DIVIDEND_WIDTH - 1);

   // quo starts as the dividend and is shifted out MSB-first while quotient
   // bits shift in from the bottom.
   logic [DIVIDEND_WIDTH-1:0] quo;
   logic [DIVISOR_WIDTH-1:0]  rem;
   logic [DIVISOR_WIDTH-1:0]  divr;
   logic [CNT_W-1:0]          it_cnt;

   logic [DIVISOR_WIDTH:0]    rem_shift;
   logic [DIVISOR_WIDTH-1:0]  rem_sub;
   logic                      ge;
   logic [DIVIDEND_WIDTH-1:0] quo_next;

   always_comb begin
      rem_shift = {rem, quo[DIVIDEND_WIDTH-1]};
      ge        = (rem_shift >= {1'b0, divr});
      // Remainder after subtraction is always below divr, so the modular
      // narrow subtraction gives the exact result whenever ge is set.
      rem_sub   = rem_shift[DIVISOR_WIDTH-1:0] - divr;
      quo_next  = {quo[DIVIDEND_WIDTH-2:0], ge};
   end

   assign quotient_next = quo_next[QUOTIENT_WIDTH-1:0];
   assign done          = busy && (it_cnt == LAST_IT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         it_cnt <= '0;
         quo    <= '0;
         rem    <= '0;
         divr   <= '0;
      end else if (start && !busy) begin
         busy   <= 1'b1;
         it_cnt <= '0;
         quo    <= dividend;
         rem    <= '0;
         divr   <= divisor;
      end else if (busy) begin
         quo    <= quo_next;
         rem    <= ge ? rem_sub : rem_shift[DIVISOR_WIDTH-1:0];
         it_cnt <= it_cnt + CNT_W'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/kmeans_centroid_update_k3_d2.sv
// kmeans_centroid_update_k3_d2
//   Closes the k-means loop: accumulates per-centroid coordinate sums and sample
//   counts from classified points, and at end of pass replaces each centroid by
//   the mean of its samples using one shared sequential divider.
// Ports
//   clk, rst_n                    : clock, synchronous active-low reset
//   in_valid / in_ready           : point handshake (in_ready high only while accumulating)
//   input_data0/1                 : point coordinates
//   selected_centroid             : centroid id from the classifier (0..2 valid)
//   end_of_pass                   : last point of the pass (qualified by in_ready)
//   centroid{0,1,2}_d{0,1}        : current centroid set
//   update_done                   : one-cycle pulse when the new set is in place
//   overflow                      : sticky, a sample was dropped
module kmeans_centroid_update_k3_d2
   import kmeans_pkg::*;
#(
   parameter int INPUT_DATA_WIDTH  = DEF_INPUT_DATA_WIDTH,
   parameter int CENTROID_ID_WIDTH = DEF_CENTROID_ID_WIDTH,
   parameter int COUNT_WIDTH       = DEF_COUNT_WIDTH,
   parameter int SUM_WIDTH         = sum_width_of(INPUT_DATA_WIDTH, COUNT_WIDTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INPUT_DATA_WIDTH-1:0]  input_data0,
   input  logic [INPUT_DATA_WIDTH-1:0]  input_data1,
   input  logic [CENTROID_ID_WIDTH-1:0] selected_centroid,
   input  logic                         end_of_pass,
   output logic [INPUT_DATA_WIDTH-1:0]  centroid0_d0,
   output logic [INPUT_DATA_WIDTH-1:0]  centroid0_d1,
   output logic [INPUT_DATA_WIDTH-1:0]  centroid1_d0,
   output logic [INPUT_DATA_WIDTH-1:0]  centroid1_d1,
   output logic [INPUT_DATA_WIDTH-1:0]  centroid2_d0,
   output logic [INPUT_DATA_WIDTH-1:0]  centroid2_d1,
   output logic                         update_done,
   output logic                         overflow
);

   kmeans_state_e state;
   logic [SLOT_W-1:0] slot;

   logic [NUM_CENTROIDS-1:0][NUM_DIMS-1:0][SUM_WIDTH-1:0]        sum;
   logic [NUM_CENTROIDS-1:0][COUNT_WIDTH-1:0]                    cnt;
   logic [NUM_CENTROIDS-1:0][NUM_DIMS-1:0][INPUT_DATA_WIDTH-1:0] cent;

   logic [NUM_DIMS-1:0][INPUT_DATA_WIDTH-1:0] data;
   logic [NUM_CENTROIDS-1:0] hit;
   logic [NUM_CENTROIDS-1:0] full;
   logic                     accept;
   logic                     drop;

   logic                        div_start;
   logic                        div_busy;
   logic                        div_done;
   logic [SUM_WIDTH-1:0]        div_dividend;
   logic [COUNT_WIDTH-1:0]      div_divisor;
   logic [INPUT_DATA_WIDTH-1:0] div_quotient;

   assign data[0] = input_data0;
   assign data[1] = input_data1;

   assign centroid0_d0 = cent[0][0];
   assign centroid0_d1 = cent[0][1];
   assign centroid1_d0 = cent[1][0];
   assign centroid1_d1 = cent[1][1];
   assign centroid2_d0 = cent[2][0];
   assign centroid2_d1 = cent[2][1];

   // in_ready is only ever high in ACC, so it alone qualifies a point.
   assign accept = in_valid && in_ready;

   // An id with no matching centroid, or a saturated counter, drops the sample.
   always_comb begin
      hit  = '0;
      full = '0;
      for (int k = 0; k < NUM_CENTROIDS; k++) begin
         hit[k]  = (selected_centroid == CENTROID_ID_WIDTH'(k));
         full[k] = &cnt[k];
      end
      drop = (hit == '0) || ((hit & full) != '0);
   end

   // Slot s covers centroid s/2, dimension s%2.
   always_comb begin
      div_dividend = '0;
      div_divisor  = '0;
      for (int k = 0; k < NUM_CENTROIDS; k++) begin
         for (int d = 0; d < NUM_DIMS; d++) begin
            if (slot == SLOT_W'(NUM_DIMS * k + d)) begin
               div_dividend = sum[k][d];
               div_divisor  = cnt[k];
            end
         end
      end
   end

   // A new division starts the cycle after the previous one finishes, giving
   // every slot exactly one start cycle plus SUM_WIDTH iterations.
   assign div_start = (state == ST_DIV) && !div_busy;

   kmeans_seq_divider #(
      .DIVIDEND_WIDTH (SUM_WIDTH),
      .DIVISOR_WIDTH  (COUNT_WIDTH),
      .QUOTIENT_WIDTH (INPUT_DATA_WIDTH)
   ) u_div (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (div_start),
      .dividend      (div_dividend),
      .divisor       (div_divisor),
      .busy          (div_busy),
      .done          (div_done),
      .quotient_next (div_quotient)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_ACC;
         slot        <= '0;
         in_ready    <= 1'b0;
         update_done <= 1'b0;
         overflow    <= 1'b0;
         sum         <= '0;
         cnt         <= '0;
         cent        <= '0;
      end else begin
         update_done <= 1'b0;
         case (state)
            ST_ACC: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (drop) begin
                     overflow <= 1'b1;
                  end else begin
                     for (int k = 0; k < NUM_CENTROIDS; k++) begin
                        if (hit[k]) begin
                           cnt[k] <= cnt[k] + COUNT_WIDTH'(1);
                           for (int d = 0; d < NUM_DIMS; d++)
                              sum[k][d] <= sum[k][d] + SUM_WIDTH'(data[d]);
                        end
                     end
                  end
               end
               // The same-cycle point is folded in above before sums are divided.
               if (in_ready && end_of_pass) begin
                  state    <= ST_DIV;
                  slot     <= '0;
                  in_ready <= 1'b0;
               end
            end

            ST_DIV: begin
               if (div_done) begin
                  // An empty cluster keeps its previous centroid.
                  for (int k = 0; k < NUM_CENTROIDS; k++) begin
                     for (int d = 0; d < NUM_DIMS; d++) begin
                        if (slot == SLOT_W'(NUM_DIMS * k + d) && cnt[k] != '0)
                           cent[k][d] <= div_quotient;
                     end
                  end
                  if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
                     state       <= ST_DONE;
                     update_done <= 1'b1;
                  end else begin
                     slot <= slot + SLOT_W'(1);
                  end
               end
            end

            ST_DONE: begin
               sum      <= '0;
               cnt      <= '0;
               state    <= ST_ACC;
               in_ready <= 1'b1;
            end

            default: begin
               state    <= ST_ACC;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d2.sv
// Bench for kmeans_centroid_update_k3_d2. A reference model tracks per-centroid
// sums/counts with plain integer arithmetic; each end of pass pushes the
// expected centroid set into a queue that a monitor checks on update_done.
// A second instance with a 2-bit counter covers count saturation.
module tb_kmeans_centroid_update_k3_d2;

   localparam int MAXCNT   = 65535;
   localparam int LATENCY  = 6 * 33;   // eop edge -> update_done edge
   localparam int S_LAT    = 6 * 19;   // same for the 2-bit-counter instance

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int cmp = 0;
   int errs = 0;

   // main instance
   logic        in_valid = 1'b0, end_of_pass = 1'b0, in_ready, update_done, overflow;
   logic [15:0] input_data0 = '0, input_data1 = '0;
   logic [1:0]  selected_centroid = '0;
   logic [15:0] c0d0, c0d1, c1d0, c1d1, c2d0, c2d1;

   kmeans_centroid_update_k3_d2 u_dut (
      .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
      .input_data0 (input_data0), .input_data1 (input_data1),
      .selected_centroid (selected_centroid), .end_of_pass (end_of_pass),
      .centroid0_d0 (c0d0), .centroid0_d1 (c0d1), .centroid1_d0 (c1d0),
      .centroid1_d1 (c1d1), .centroid2_d0 (c2d0), .centroid2_d1 (c2d1),
      .update_done (update_done), .overflow (overflow)
   );

   // small-counter instance
   logic        s_in_valid = 1'b0, s_eop = 1'b0, s_in_ready, s_update_done, s_overflow;
   logic [15:0] s_d0 = '0, s_d1 = '0;
   logic [1:0]  s_id = '0;
   logic [15:0] s0d0, s0d1, s1d0, s1d1, s2d0, s2d1;

   kmeans_centroid_update_k3_d2 #(.COUNT_WIDTH(2)) u_small (
      .clk (clk), .rst_n (rst_n), .in_valid (s_in_valid), .in_ready (s_in_ready),
      .input_data0 (s_d0), .input_data1 (s_d1),
      .selected_centroid (s_id), .end_of_pass (s_eop),
      .centroid0_d0 (s0d0), .centroid0_d1 (s0d1), .centroid1_d0 (s1d0),
      .centroid1_d1 (s1d1), .centroid2_d0 (s2d0), .centroid2_d1 (s2d1),
      .update_done (s_update_done), .overflow (s_overflow)
   );

   // reference model
   longint msum [3][2];
   int     mcnt [3];
   int     mcent[3][2];
   bit     movf;

   typedef struct packed {
      logic [5:0][15:0] c;
      logic             ovf;
      logic [31:0]      t_eop;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check(input string name, input longint act, input longint exp);
      cmp++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int cval(input int s);
      case (s)
         0: return int'(c0d0);
         1: return int'(c0d1);
         2: return int'(c1d0);
         3: return int'(c1d1);
         4: return int'(c2d0);
         5: return int'(c2d1);
         default: return -1;
      endcase
   endfunction

   task automatic model_clear_all();
      for (int k = 0; k < 3; k++) begin
         mcnt[k] = 0;
         for (int d = 0; d < 2; d++) begin
            msum[k][d]  = 0;
            mcent[k][d] = 0;
         end
      end
      movf = 1'b0;
   endtask

   task automatic model_accept(input int id, input int x, input int y);
      if (id > 2) begin
         movf = 1'b1;
      end else if (mcnt[id] == MAXCNT) begin
         movf = 1'b1;
      end else begin
         msum[id][0] += x;
         msum[id][1] += y;
         mcnt[id]++;
      end
   endtask

   task automatic model_end_pass();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         for (int d = 0; d < 2; d++) begin
            if (mcnt[k] != 0) mcent[k][d] = int'(msum[k][d] / mcnt[k]);
            e.c[2*k+d] = 16'(mcent[k][d]);
            msum[k][d] = 0;
         end
         mcnt[k] = 0;
      end
      e.ovf   = movf;
      e.t_eop = 32'(cyc);
      exp_q.push_back(e);
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst_n && update_done) begin
         if (exp_q.size() == 0) begin
            cmp++;
            errs++;
            $display("FAIL unexpected_update_done: got pulse at cycle %0d, required none", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            for (int s = 0; s < 6; s++)
               check($sformatf("centroid%0d_d%0d", s / 2, s % 2), cval(s), mon_e.c[s]);
            check("overflow", overflow, mon_e.ovf);
            check("latency", cyc - int'(mon_e.t_eop), LATENCY);
         end
      end
   end

   // stimulus helpers (main instance)
   task automatic send_point(input bit v, input int id, input int x, input int y, input bit eop);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         cmp++;
         errs++;
         $display("FAIL in_ready_wait: got in_ready=0 after %0d cycles, required 1", guard);
         return;
      end
      in_valid          = v;
      input_data0       = 16'(x);
      input_data1       = 16'(y);
      selected_centroid = 2'(id);
      end_of_pass       = eop;
      @(posedge clk);
      #1;
      if (v)   model_accept(id, x, y);
      if (eop) model_end_pass();
      in_valid    = 1'b0;
      end_of_pass = 1'b0;
   endtask

   // Waits out DIV/DONE; with noise, in_valid/end_of_pass toggle while busy
   // and must be ignored.
   task automatic wait_pass_end(input bit noise);
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
         if (!in_ready && noise) begin
            in_valid          = 1'b1;
            input_data0       = 16'($urandom_range(0, 65535));
            input_data1       = 16'($urandom_range(0, 65535));
            selected_centroid = 2'($urandom_range(0, 3));
            end_of_pass       = 1'($urandom_range(0, 1));
         end
      end while (!in_ready && guard < 400);
      in_valid    = 1'b0;
      end_of_pass = 1'b0;
      if (!in_ready) begin
         cmp++;
         errs++;
         $display("FAIL pass_end_timeout: got in_ready=0 after %0d cycles, required 1", guard);
      end
   endtask

   task automatic random_pass(input int n, input bit allow_bad);
      int id;
      bit v;
      for (int i = 0; i < n; i++) begin
         id = $urandom_range(0, 2);
         if (allow_bad && $urandom_range(0, 9) == 0) id = 3;
         v = ($urandom_range(0, 5) != 0);
         send_point(v, id, $urandom_range(0, 65535), $urandom_range(0, 65535), i == n - 1);
      end
   endtask

   task automatic check_centroids(input string tag, input int e0, input int e1, input int e2,
                                  input int e3, input int e4, input int e5);
      int ev[6];
      ev = '{e0, e1, e2, e3, e4, e5};
      for (int s = 0; s < 6; s++)
         check($sformatf("%s_c%0d_d%0d", tag, s / 2, s % 2), cval(s), ev[s]);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish by time limit, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sp0[4];
      int sp1[4];
      int t0;
      int guard;
      model_clear_all();

      // reset held 3 cycles
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_centroids("reset", 0, 0, 0, 0, 0, 0);
      check("reset_in_ready", in_ready, 0);
      check("reset_update_done", update_done, 0);
      check("reset_overflow", overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_release", in_ready, 1);

      // saturating 2-bit counter: the 4th point to id0 is dropped
      sp0 = '{1, 2, 6, 100};
      sp1 = '{2, 4, 9, 100};
      check("small_in_ready", s_in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         s_in_valid = 1'b1;
         s_d0       = 16'(sp0[i]);
         s_d1       = 16'(sp1[i]);
         s_id       = 2'd0;
         s_eop      = (i == 3);
      end
      @(posedge clk);
      #1;
      t0         = cyc;
      s_in_valid = 1'b0;
      s_eop      = 1'b0;
      guard      = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!s_update_done && guard < 300);
      check("small_update_done_seen", s_update_done, 1);
      check("small_latency", cyc - t0, S_LAT);
      check("small_c0_d0", s0d0, 3);
      check("small_c0_d1", s0d1, 5);
      check("small_c1_d0", s1d0, 0);
      check("small_c2_d1", s2d1, 0);
      check("small_overflow", s_overflow, 1);

      // single cluster
      send_point(1, 0, 10, 20, 0);
      send_point(1, 0, 12, 22, 0);
      send_point(1, 0, 14, 24, 1);
      wait_pass_end(1);
      check_centroids("single", 12, 22, 0, 0, 0, 0);

      // truncation and full-scale values
      send_point(1, 1, 3, 4, 0);
      send_point(1, 1, 4, 4, 0);
      send_point(1, 2, 65535, 65535, 0);
      send_point(1, 2, 65535, 65535, 1);
      wait_pass_end(1);
      check_centroids("trunc", 12, 22, 3, 4, 65535, 65535);

      // empty cluster keeps its value; invalid id raises overflow
      send_point(1, 2, 100, 200, 1);
      wait_pass_end(0);
      check_centroids("set_c2", 12, 22, 3, 4, 100, 200);
      send_point(1, 0, 7, 7, 0);
      send_point(1, 3, 1, 1, 0);
      send_point(0, 0, 0, 0, 0);
      send_point(1, 1, 8, 9, 1);
      wait_pass_end(1);
      check_centroids("empty", 7, 7, 8, 9, 100, 200);
      check("overflow_bad_id", overflow, 1);

      // end_of_pass without in_valid: that cycle's data is not accumulated
      send_point(1, 0, 50, 60, 0);
      send_point(0, 1, 999, 999, 1);
      wait_pass_end(1);
      check_centroids("eop_novalid", 50, 60, 8, 9, 100, 200);

      // random passes
      for (int p = 0; p < 4; p++) begin
         random_pass($urandom_range(8, 40), p[0]);
         wait_pass_end(p[1]);
      end

      // reset while slot 3 is dividing: no pulse, everything cleared
      random_pass(10, 0);
      repeat (110) begin
         @(negedge clk);
         in_valid    = 1'b1;
         input_data0 = 16'($urandom_range(0, 65535));
         input_data1 = 16'($urandom_range(0, 65535));
      end
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      end_of_pass = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      model_clear_all();
      rst_n = 1'b1;
      repeat (250) @(negedge clk);
      check_centroids("midreset", 0, 0, 0, 0, 0, 0);
      check("midreset_overflow", overflow, 0);
      check("midreset_in_ready", in_ready, 1);

      random_pass(15, 1);
      wait_pass_end(1);
      random_pass(20, 0);
      wait_pass_end(1);

      check("pending_expectations", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
